// File: rtl/updown_pkg.sv
// Shared encodings for the up/down modulo counter family.
package updown_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;
  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_HOLD  = 1'b1;

endpackage

// File: rtl/updown_next_val.sv
// Next-count logic: one step up or down within 0..MAX_VAL, with wrap and blocked-step detection.
module updown_next_val
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MAX_VAL = 7
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_mode,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap_evt,
  output logic             o_block_evt
);

  localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH:0] w_cnt_ext;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  // One extra bit so the step past either bound is visible before it is folded back.
  assign w_cnt_ext = {1'b0, i_count};
  assign w_inc     = w_cnt_ext + 1'b1;
  assign w_dec     = w_cnt_ext - 1'b1;

  always_comb begin
    o_next      = i_count;
    o_wrap_evt  = 1'b0;
    o_block_evt = 1'b0;
    if (i_mode == MODE_UP) begin
      if (w_inc > MaxExt) begin
        if (i_sat == SAT_HOLD) begin
          o_block_evt = 1'b1;
        end else begin
          o_next     = '0;
          o_wrap_evt = 1'b1;
        end
      end else begin
        o_next = w_inc[WIDTH-1:0];
      end
    end else begin
      // Borrow out of the top bit means the step went below zero.
      if (w_dec[WIDTH]) begin
        if (i_sat == SAT_HOLD) begin
          o_block_evt = 1'b1;
        end else begin
          o_next     = MaxVal;
          o_wrap_evt = 1'b1;
        end
      end else begin
        o_next = w_dec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate, terminal count and sticky overflow.
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MAX_VAL = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  if (WIDTH < 1 || MAX_VAL < 1 ||
      longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
    $error("updown_counter_mod: MAX_VAL must lie in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next;
  logic             w_wrap_evt;
  logic             w_block_evt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;

  updown_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next_val (
    .i_count     (r_count),
    .i_mode      (i_mode),
    .i_sat       (i_sat),
    .o_next      (w_next),
    .o_wrap_evt  (w_wrap_evt),
    .o_block_evt (w_block_evt)
  );

  assign w_load_clamped = (i_load_val > MaxVal) ? MaxVal : i_load_val;
  // Load overrides enable, so a step only happens when no load is pending.
  assign w_step         = i_en && !i_load;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= (i_mode == MODE_DOWN) ? MaxVal : '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_load) begin
        r_count <= w_load_clamped;
      end else if (i_en) begin
        r_count <= w_next;
      end
      r_wrap <= w_step && w_wrap_evt;
      // A coincident event beats the clear.
      if (w_step && (w_wrap_evt || w_block_evt)) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_count = r_count;
  assign o_wrap  = r_wrap;
  assign o_ovf   = r_ovf;
  assign o_tc    = ((i_mode == MODE_UP) && (r_count == MaxVal)) ||
                   ((i_mode == MODE_DOWN) && (r_count == '0));

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised synchronous up/down modulo counter with parallel load, count enable, selectable wrap or saturate at the bounds, terminal-count detect and a sticky overflow flag. It is the general-purpose successor to the fixed 3-bit up/down counter. It serves as a building block for timers, address generators and dividers elsewhere in the sequential-circuits library.

## Interface
- WIDTH, 3, counter width in bits; ≥ 1
- MAX_VAL, 7, top of count range (range is 0..MAX_VAL); 1 ≤ MAX_VAL ≤ 2^WIDTH−1, elaboration error otherwise

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- mode  in  1  direction: 0 = up, 1 = down
- sat  in  1  bound behaviour: 0 = wrap, 1 = saturate
- load  in  1  parallel load strobe
- load_val  in  WIDTH  load value
- ovf_clr  in  1  clears sticky overflow flag
- count  out  WIDTH  current count (registered)
- tc  out  1  terminal count, combinational from count and mode
- wrap  out  1  registered one-cycle pulse, high the cycle after a wrap occurred
- ovf  out  1  sticky overflow/underflow flag (registered)

## Operation
- Priority per edge: rst > load > en; all other cases hold count.
- rst: count ← MAX_VAL if mode=1, else 0; wrap ← 0; ovf ← 0.
- load: count ← min(load_val, MAX_VAL); load_val > MAX_VAL clamps to MAX_VAL, no flag. Load with en=1 ignores en; no wrap/ovf effect.
- en, mode=0: count < MAX_VAL → count+1; count = MAX_VAL → 0 (sat=0, wrap event) or hold (sat=1, blocked event).
- en, mode=1: count > 0 → count−1; count = 0 → MAX_VAL (sat=0, wrap event) or hold (sat=1, blocked event).
- Arithmetic in WIDTH+1 bits internally; count never leaves 0..MAX_VAL, including for non-power-of-two MAX_VAL.
- tc = (mode=0 and count=MAX_VAL) or (mode=1 and count=0); independent of en.
- wrap ← 1 on edge where a wrap event occurs, else 0.
- ovf ← 1 on wrap event or blocked event; ovf_clr clears; set and clear on same edge → set wins.
- mode/sat may change any cycle; they take effect on the next edge only. No state machine beyond count/wrap/ovf registers.

## Timing
- count: latency 1 cycle from en/load/rst to new value.
- tc: zero-latency combinational from count and mode (reflects mode change in same cycle).
- wrap: asserted exactly one cycle, in the cycle following the wrapping edge (coincides with count = 0 or MAX_VAL).
- ovf: visible cycle after the event; stays high until ovf_clr edge without a coincident event.
- rst mid-count: next cycle count at reset value, wrap=0, ovf=0, regardless of load/en.

## Structure
- Package updown_pkg: MODE_UP=1'b0, MODE_DOWN=1'b1, SAT_WRAP=1'b0, SAT_HOLD=1'b1.
- One sub-module updown_next_val: combinational next-count, wrap-event and blocked-event from count, mode, sat, MAX_VAL; top holds registers, priority, load clamp, tc.

## Test plan
- WIDTH=3, MAX_VAL=7, rst with mode=1 → count=7; rst with mode=0 → count=0, wrap=0, ovf=0.
- Up, sat=0, en=1 from 0 for 9 cycles → count 1..7,0,1; tc high at 7; wrap high one cycle when count=0; ovf=1 after.
- WIDTH=4, MAX_VAL=9, down, sat=1 from 2 for 4 cycles → 1,0,0,0; tc=1 at 0; wrap never; ovf set on first blocked edge.
- load=1, load_val=12 with MAX_VAL=9, en=1 → count=9 next cycle, no wrap, ovf unchanged.
- ovf=1, ovf_clr=1 on same edge as a wrap event → ovf stays 1; next edge ovf_clr=1, no event → ovf=0.
- Mid-count (count=5) rst=1 with load=1, load_val=2, en=1, mode=0 → count=0, not 2 or 6.
